// File: rtl/exu_sequencer.sv
// exu_sequencer
//   Execute-stage sequencer for the multi-cycle units (integer multiplier and
//   multi-cycle FALU). Issues start pulses, holds the pipeline stall while a
//   unit is busy, and substitutes the unit result for the single-cycle ALU
//   result on the path into Reg_M. Handles flush aborts and a completion
//   watchdog.
//
//   State table:
//     IDLE     | no op in flight; single-cycle results pass through
//     WAIT_MUL | multiplier running, pipeline stalled
//     WAIT_FPU | FALU running, pipeline stalled
//     DONE     | unit result presented to Reg_M for one cycle
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   E_valid/E_class/E_rd/E_fp E-stage instruction info
//   flush                     kill E-stage instruction
//   alu_result                single-cycle ALU/FALU result
//   mul_*/fpu_*               unit handshake (start out, done/result in)
//   unit_abort                cancel pulse to the active unit
//   stall                     freeze PC/Reg_D/Reg_E
//   ex_valid/result/rd/fp     result path into Reg_M
//   busy, wd_err, stall_cnt   status
module exu_sequencer #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E_valid,
  input  logic [1:0]       E_class,
  input  logic [4:0]       E_rd,
  input  logic             E_fp,
  input  logic             flush,
  input  logic [31:0]      alu_result,
  input  logic             mul_done,
  input  logic [31:0]      mul_result,
  input  logic             fpu_done,
  input  logic [31:0]      fpu_result,
  output logic             mul_start,
  output logic             fpu_start,
  output logic             unit_abort,
  output logic             stall,
  output logic             ex_valid,
  output logic [31:0]      ex_result,
  output logic [4:0]       ex_rd,
  output logic             ex_fp,
  output logic             busy,
  output logic             wd_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_MUL = 2'd1;
  localparam logic [1:0] S_WAIT_FPU = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam int WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCNT_W-1:0] WD_LAST = WCNT_W'(MAX_WAIT - 1);

  logic [1:0]        state, state_d;
  logic [31:0]       res_q;
  logic [4:0]        rd_q;
  logic              fp_q;
  logic [WCNT_W-1:0] wcnt;
  logic              wd_err_q;

  logic        in_wait, unit_done, wd_hit, issue_ok;
  logic [31:0] unit_res;
  logic        mul_start_c, fpu_start_c, abort_c, stall_c, valid_c;
  logic [31:0] res_c;
  logic [4:0]  rd_c;
  logic        fp_c;

  assign in_wait   = (state == S_WAIT_MUL) || (state == S_WAIT_FPU);
  assign unit_done = (state == S_WAIT_MUL) ? mul_done : fpu_done;
  assign unit_res  = (state == S_WAIT_MUL) ? mul_result : fpu_result;
  assign issue_ok  = E_valid & ~flush;
  // A real completion in the last allowed cycle beats the watchdog; flush beats both.
  assign wd_hit    = in_wait & ~flush & ~unit_done & (wcnt == WD_LAST);

  always_comb begin
    state_d     = state;
    mul_start_c = 1'b0;
    fpu_start_c = 1'b0;
    abort_c     = 1'b0;
    stall_c     = 1'b0;
    valid_c     = 1'b0;
    res_c       = res_q;
    rd_c        = rd_q;
    fp_c        = fp_q;
    case (state)
      S_IDLE: begin
        res_c = alu_result;
        rd_c  = E_rd;
        fp_c  = E_fp;
        if (issue_ok && E_class == 2'b01) begin
          mul_start_c = 1'b1;
          stall_c     = 1'b1;
          state_d     = S_WAIT_MUL;
        end else if (issue_ok && E_class == 2'b10) begin
          fpu_start_c = 1'b1;
          stall_c     = 1'b1;
          state_d     = S_WAIT_FPU;
        end else begin
          valid_c = issue_ok;
        end
      end
      S_WAIT_MUL, S_WAIT_FPU: begin
        if (flush) begin
          abort_c = 1'b1;
          state_d = S_IDLE;
        end else if (unit_done) begin
          stall_c = 1'b1;
          state_d = S_DONE;
        end else if (wd_hit) begin
          abort_c = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: begin
        valid_c = ~flush;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      res_q     <= '0;
      rd_q      <= '0;
      fp_q      <= 1'b0;
      wcnt      <= '0;
      wd_err_q  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_d;
      if (mul_start_c || fpu_start_c) begin
        rd_q <= E_rd;
        fp_q <= E_fp;
        wcnt <= '0;
      end else if (in_wait) begin
        wcnt <= wcnt + 1'b1;
      end
      if (in_wait && !flush && unit_done)
        res_q <= unit_res;
      if (wd_hit)
        wd_err_q <= 1'b1;
      if (stall_c && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Every output, including the combinational pass-through, is forced low in reset.
  assign mul_start  = rst & mul_start_c;
  assign fpu_start  = rst & fpu_start_c;
  assign unit_abort = rst & abort_c;
  assign stall      = rst & stall_c;
  assign ex_valid   = rst & valid_c;
  assign ex_result  = rst ? res_c : 32'd0;
  assign ex_rd      = rst ? rd_c : 5'd0;
  assign ex_fp      = rst & fp_c;
  assign busy       = rst & (state != S_IDLE);
  assign wd_err     = wd_err_q;

endmodule
